fx2_fifo_master: RTL and testbench
==================================

FX2_FIFO_MASTER -- requirements
Module: fx2_fifo_master

Interface
REQ-001 Parameters SHALL be:
- OUT_ADR, default 2'b00: FIFOADR of the EP2 command endpoint (host->device).
- IN_ADR, default 2'b10: FIFOADR of the EP6 data endpoint (device->host).
- BURST, default 16: maximum bytes per grant before re-arbitration.
REQ-002 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be:
- ifclk  in  1  FX2 interface clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- fd  inout  8  FX2 data bus.
- slrd  out  1  read strobe, active-low.
- slwr  out  1  write strobe, active-low.
- sloe  out  1  FX2 output enable, active-low.
- fifoadr  out  2  endpoint select.
- pktend  out  1  packet commit, active-low.
- flags  in  3  [0]=EP2 not-empty, [1]=EP6 not-full, [2]=EP8 not-full (unused).
- cmd_data  out  8  received command byte.
- cmd_valid  out  1  cmd_data holds an unconsumed byte.
- cmd_ready  in  1  consumer accepts cmd_data this cycle.
- data_in  in  8  byte to send to host.
- data_valid  in  1  data_in is valid.
- data_ready  out  1  byte accepted this cycle.
- data_flush  in  1  one-cycle request to commit a short packet.

Function
REQ-004 The FSM SHALL use states IDLE, RD_SETUP, READ, WR_SETUP, WRITE and PKTEND.
REQ-005 IDLE SHALL arbitrate round-robin between the read side (eligible when flags[0]=1) and the write side (eligible when data_valid=1 and flags[1]=1); the side not served last wins a tie.
REQ-006 IDLE SHALL go to WR_SETUP for a flush when flush_pending=1, the write side is not eligible, and the read side is not eligible.
REQ-007 RD_SETUP SHALL register fifoadr=OUT_ADR and sloe=0 for exactly one cycle (bus turnaround), then enter READ.
REQ-008 In READ, slrd SHALL be combinationally 0 iff flags[0]=1, (cmd_valid=0 or cmd_ready=1), and beat count < BURST; on that edge fd SHALL be captured into cmd_data and cmd_valid set.
REQ-009 cmd_valid SHALL clear on cmd_valid and cmd_ready with no simultaneous capture; a simultaneous capture SHALL keep cmd_valid=1 with the new byte.
REQ-010 READ SHALL return to IDLE, restoring sloe=1, when flags[0]=0 or beat count reaches BURST.
REQ-011 WR_SETUP SHALL register fifoadr=IN_ADR with sloe=1 for one cycle, then enter PKTEND if entered for a flush, otherwise WRITE.
REQ-012 In WRITE, data_ready SHALL be flags[1] AND (beat count < BURST).
REQ-013 In WRITE, slwr SHALL be combinationally 0 iff data_valid and data_ready, with fd driven to data_in in the same cycle (zero latency).
REQ-014 WRITE SHALL exit when data_valid=0, flags[1]=0, or BURST is reached; the exit SHALL go to PKTEND if flush_pending=1, else to IDLE.
REQ-015 PKTEND SHALL assert pktend=0 for exactly one cycle with fifoadr=IN_ADR, clear flush_pending, then go to IDLE.
REQ-016 fd SHALL be driven only in WR_SETUP, WRITE and PKTEND, and SHALL be high-Z otherwise; fd SHALL never be driven while sloe=0.
REQ-017 data_flush SHALL set flush_pending (sticky); a flush arriving during PKTEND SHALL remain pending for a further PKTEND.
REQ-018 The beat counter SHALL be ceil(log2(BURST+1)) bits wide and SHALL clear on each entry to READ or WRITE.
REQ-019 data_ready SHALL be 0 outside WRITE.

Reset
REQ-020 Reset SHALL set: state=IDLE, sloe=1, slrd=1, slwr=1, pktend=1, fifoadr=OUT_ADR, fd=high-Z, cmd_valid=0, cmd_data=0, data_ready=0, flush_pending=0, beat count=0, and round-robin pointer=write-last.
REQ-021 Reset asserted mid-burst SHALL deassert all strobes in the same cycle (combinational gating on state) and discard any partial command byte.

Structure
REQ-022 A shared package fx2_pkg SHALL hold the state encoding, the endpoint address constants (EP2=00, EP4=01, EP6=10, EP8=11) and the flag bit indices.
REQ-023 The block SHALL be one module with no sub-modules; the fd tristate SHALL be a single continuous assignment.

Verification
REQ-024 The bench SHALL connect the block to the FX2 bus model and cover:
- Host commits 3 cmd bytes A1 A2 A3 with cmd_ready=1 -> RD_SETUP then 3 slrd low cycles, cmd_data sequence A1,A2,A3, cmd_valid then 0.
- Stream 40 bytes 00..27 with data_valid held -> bursts of 16,16,8 bytes in order on EP6 (fifoadr=10), one IDLE/WR_SETUP gap between bursts.
- Pulse data_flush after 5 bytes -> exactly one pktend low cycle after the 5th slwr, fifoadr=10 during it.
- Commands pending plus data_valid=1 together -> alternating read/write grants, neither side starved; sloe=0 never coincides with fd driven.
- cmd_ready=0 with 2 bytes waiting -> one byte captured, slrd held high, second byte read only after cmd_ready=1.
- Reset asserted in WRITE mid-burst -> next cycle slwr=1, fd high-Z, state IDLE, data_ready=0.

Source files
------------

// File: rtl/fx2_pkg.sv
// Shared definitions for the FX2 slave-FIFO master: FSM encoding, endpoint addresses, flag bits.
// Latency: none, declarations only.
// Backpressure: not applicable.
package fx2_pkg;

  // Master FSM states
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_SETUP = 3'd1,
    READ     = 3'd2,
    WR_SETUP = 3'd3,
    WRITE    = 3'd4,
    PKTEND   = 3'd5
  } state_t;

  // FIFOADR values of the four FX2 endpoints
  localparam logic [1:0] EP2_ADR = 2'b00;
  localparam logic [1:0] EP4_ADR = 2'b01;
  localparam logic [1:0] EP6_ADR = 2'b10;
  localparam logic [1:0] EP8_ADR = 2'b11;

  // Bit positions inside the FX2 flags bus
  localparam int FLAG_EP2_NE = 0;  // EP2 holds at least one host byte
  localparam int FLAG_EP6_NF = 1;  // EP6 can take another byte
  localparam int FLAG_EP8_NF = 2;  // EP8 not-full, not used by this master

  // Width of a counter that must be able to hold the value BURST itself
  function automatic int beat_width(input int burst);
    return $clog2(burst + 1);
  endfunction

endpackage

// File: rtl/fx2_fifo_master.sv
// FX2 slave-FIFO master: reads EP2 command bytes to cmd_*, writes data_* bytes to EP6, commits short packets.
// Latency: a read byte is on cmd_data the cycle after its slrd edge; data_in reaches fd in the same cycle.
// Backpressure: cmd_ready low pauses EP2 reads; data_ready follows EP6 not-full and the per-grant burst budget.
module fx2_fifo_master
  import fx2_pkg::*;
#(
  parameter logic [1:0] OUT_ADR = EP2_ADR,
  parameter logic [1:0] IN_ADR  = EP6_ADR,
  parameter int         BURST   = 16
) (
  input  logic       ifclk,
  input  logic       reset,
  inout  wire  [7:0] fd,
  output logic       slrd,
  output logic       slwr,
  output logic       sloe,
  output logic [1:0] fifoadr,
  output logic       pktend,
  input  logic [2:0] flags,
  output logic [7:0] cmd_data,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  input  logic       data_flush
);

  localparam int            BW        = beat_width(BURST);
  localparam logic [BW-1:0] BURST_CNT = BW'(BURST);

  state_t        state;
  state_t        next_state;

  logic          sloe_q;
  logic [1:0]    fifoadr_q;
  logic [BW-1:0] beat_cnt;
  logic          last_wr;        // round-robin pointer: 1 when the write side was served last
  logic          flush_grant;    // current WR_SETUP was entered only to commit a packet
  logic          flush_pending;

  logic          rd_elig;
  logic          wr_elig;
  logic          grant_rd;
  logic          grant_wr;
  logic          grant_flush;
  logic          beat_room;
  logic          burst_done;
  logic          rd_go;
  logic          wr_go;
  logic          fd_oe;
  logic          ep8_unused;

  assign ep8_unused = flags[FLAG_EP8_NF];

  assign rd_elig    = flags[FLAG_EP2_NE];
  assign wr_elig    = data_valid && flags[FLAG_EP6_NF];
  assign beat_room  = (beat_cnt < BURST_CNT);
  assign burst_done = (beat_cnt == BURST_CNT);

  // A read beat needs a byte in EP2, room in the command holding register and burst budget left.
  // Reset gates both beats so strobes drop in the very cycle reset rises.
  assign rd_go = (state == READ) && !reset && flags[FLAG_EP2_NE]
               && (!cmd_valid || cmd_ready) && beat_room;
  assign wr_go = (state == WRITE) && !reset && data_valid
               && flags[FLAG_EP6_NF] && beat_room;

  // fd carries data_in whenever the FSM owns the bus; the host side only drives while sloe is low.
  assign fd = fd_oe ? data_in : 8'hzz;

  assign sloe    = sloe_q | reset;
  assign fifoadr = fifoadr_q;

  // State register
  always_ff @(posedge ifclk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and arbitration: the side not served last wins a tie, a lone flush commits a packet.
  always_comb begin
    next_state  = state;
    grant_rd    = 1'b0;
    grant_wr    = 1'b0;
    grant_flush = 1'b0;
    case (state)
      IDLE: begin
        if (rd_elig && wr_elig) begin
          grant_rd = last_wr;
          grant_wr = !last_wr;
        end else if (rd_elig) begin
          grant_rd = 1'b1;
        end else if (wr_elig) begin
          grant_wr = 1'b1;
        end else if (flush_pending) begin
          grant_flush = 1'b1;
        end
        if (grant_rd) begin
          next_state = RD_SETUP;
        end else if (grant_wr || grant_flush) begin
          next_state = WR_SETUP;
        end
      end
      RD_SETUP: next_state = READ;
      READ: begin
        if (!flags[FLAG_EP2_NE] || burst_done) begin
          next_state = IDLE;
        end
      end
      WR_SETUP: next_state = flush_grant ? PKTEND : WRITE;
      WRITE: begin
        if (!data_valid || !flags[FLAG_EP6_NF] || burst_done) begin
          next_state = flush_pending ? PKTEND : IDLE;
        end
      end
      PKTEND:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Strobes, bus drive and data_ready decoded from the current state; all idle while reset is high.
  always_comb begin
    slrd       = 1'b1;
    slwr       = 1'b1;
    pktend     = 1'b1;
    data_ready = 1'b0;
    fd_oe      = 1'b0;
    if (!reset) begin
      case (state)
        READ: begin
          slrd = !rd_go;
        end
        WR_SETUP: begin
          fd_oe = 1'b1;
        end
        WRITE: begin
          data_ready = flags[FLAG_EP6_NF] && beat_room;
          slwr       = !wr_go;
          fd_oe      = 1'b1;
        end
        PKTEND: begin
          pktend = 1'b0;
          fd_oe  = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Registered bus control: sloe low only across RD_SETUP and READ, fifoadr picked when a side is granted.
  always_ff @(posedge ifclk) begin
    if (reset) begin
      sloe_q    <= 1'b1;
      fifoadr_q <= OUT_ADR;
    end else begin
      sloe_q <= !((next_state == RD_SETUP) || (next_state == READ));
      if (next_state == RD_SETUP) begin
        fifoadr_q <= OUT_ADR;
      end else if (next_state == WR_SETUP) begin
        fifoadr_q <= IN_ADR;
      end
    end
  end

  // Beat counter: restarts on entry to READ or WRITE, counts every transferred byte.
  always_ff @(posedge ifclk) begin
    if (reset) begin
      beat_cnt <= '0;
    end else if (((next_state == READ) && (state != READ)) ||
                 ((next_state == WRITE) && (state != WRITE))) begin
      beat_cnt <= '0;
    end else if (rd_go || wr_go) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  // Command holding register: a capture always wins over a same-cycle consume.
  always_ff @(posedge ifclk) begin
    if (reset) begin
      cmd_data  <= 8'h00;
      cmd_valid <= 1'b0;
    end else if (rd_go) begin
      cmd_data  <= fd;
      cmd_valid <= 1'b1;
    end else if (cmd_valid && cmd_ready) begin
      cmd_valid <= 1'b0;
    end
  end

  // Arbitration memory and sticky flush; a flush arriving during PKTEND survives for the next commit.
  always_ff @(posedge ifclk) begin
    if (reset) begin
      last_wr       <= 1'b1;
      flush_grant   <= 1'b0;
      flush_pending <= 1'b0;
    end else begin
      if (grant_rd) begin
        last_wr <= 1'b0;
      end else if (grant_wr || grant_flush) begin
        last_wr <= 1'b1;
      end
      if ((state == IDLE) && (next_state == WR_SETUP)) begin
        flush_grant <= grant_flush;
      end
      if (data_flush) begin
        flush_pending <= 1'b1;
      end else if (state == PKTEND) begin
        flush_pending <= 1'b0;
      end
    end
  end

  // The master must never drive fd while the FX2 drives it.
  always_ff @(posedge ifclk) begin
    if (!reset) begin
      assert (!(fd_oe && !sloe))
        else $error("fd driven while sloe low");
    end
  end

endmodule

// File: tb/tb_fx2_fifo_master.sv
// Bench for fx2_fifo_master: FX2 bus model, directed stimulus, scoreboard queues checked by a monitor.
// Latency: monitor samples on the falling edge, stimulus changes 1 time unit after the rising edge.
// Backpressure: bounded waits everywhere; an expired bound is reported as a failed comparison.
module tb_fx2_fifo_master;
  import fx2_pkg::*;

  logic       ifclk = 1'b0;
  logic       reset = 1'b1;
  wire  [7:0] fd;
  logic       slrd, slwr, sloe, pktend;
  logic [1:0] fifoadr;
  logic [2:0] flags;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       data_ready;
  logic       data_flush = 1'b0;

  always #5 ifclk = ~ifclk;

  fx2_fifo_master #(.OUT_ADR(2'b00), .IN_ADR(2'b10), .BURST(16)) dut (
    .ifclk(ifclk), .reset(reset), .fd(fd), .slrd(slrd), .slwr(slwr), .sloe(sloe),
    .fifoadr(fifoadr), .pktend(pktend), .flags(flags), .cmd_data(cmd_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .data_in(data_in),
    .data_valid(data_valid), .data_ready(data_ready), .data_flush(data_flush)
  );

  // ---------------- FX2 bus model ----------------
  logic [7:0] ep2_mem [0:63];
  int         ep2_rd = 0;
  int         ep2_wr = 0;
  logic       ep6_full = 1'b0;
  logic       host_oe;

  assign host_oe = !sloe && (fifoadr == EP2_ADR);
  assign fd      = host_oe ? ep2_mem[ep2_rd[5:0]] : 8'hzz;
  assign flags   = {1'b1, !ep6_full, (ep2_rd != ep2_wr)};

  always @(posedge ifclk) begin
    if (!slrd && (fifoadr == EP2_ADR) && (ep2_rd != ep2_wr)) ep2_rd <= ep2_rd + 1;
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_cmd_q[$];
  logic [7:0] exp_wr_q[$];
  int         exp_run_q[$];
  int         exp_pkt_q[$];
  logic       exp_grant_q[$];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   rd_strobes = 0;
  int   total_wr = 0;
  int   run_len = 0;
  int   pkt_cnt = 0;
  int   contention = 0;
  int   turnaround_bad = 0;
  logic prev_sloe = 1'b1;
  logic log_grants = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Monitor: pops the expected response whenever the DUT presents one
  initial forever begin
    @(negedge ifclk);
    if (!sloe && dut.fd_oe) contention++;
    if (!slrd) begin
      rd_strobes++;
      if (prev_sloe || sloe) turnaround_bad++;
    end
    prev_sloe = sloe;
    if (cmd_valid && cmd_ready) begin
      check("cmd_expected", (exp_cmd_q.size() > 0) ? 1 : 0, 1);
      if (exp_cmd_q.size() > 0) check("cmd_data", cmd_data, exp_cmd_q.pop_front());
    end
    if (!slwr) begin
      total_wr++;
      run_len++;
      check("wr_fifoadr", fifoadr, 2);
      check("wr_expected", (exp_wr_q.size() > 0) ? 1 : 0, 1);
      if (exp_wr_q.size() > 0) check("wr_byte", fd, exp_wr_q.pop_front());
    end else if (run_len > 0) begin
      check("run_expected", (exp_run_q.size() > 0) ? 1 : 0, 1);
      if (exp_run_q.size() > 0) check("burst_len", run_len, exp_run_q.pop_front());
      run_len = 0;
    end
    if (!pktend) begin
      pkt_cnt++;
      check("pkt_fifoadr", fifoadr, 2);
      check("pkt_expected", (exp_pkt_q.size() > 0) ? 1 : 0, 1);
      if (exp_pkt_q.size() > 0) check("pkt_after_bytes", total_wr, exp_pkt_q.pop_front());
    end
    if (log_grants && ((dut.state == RD_SETUP) || (dut.state == WR_SETUP))) begin
      check("grant_expected", (exp_grant_q.size() > 0) ? 1 : 0, 1);
      if (exp_grant_q.size() > 0) check("grant_is_write", (dut.state == WR_SETUP) ? 1 : 0,
                                        exp_grant_q.pop_front() ? 1 : 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_cmd(input logic [7:0] b);
    ep2_mem[ep2_wr[5:0]] = b;
    ep2_wr++;
    exp_cmd_q.push_back(b);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge ifclk);
    #1;
  endtask

  task automatic stream(input string name, input logic [7:0] base, input int n, input int budget);
    int   idx = 0;
    int   cyc = 0;
    logic take;
    for (int i = 0; i < n; i++) exp_wr_q.push_back(base + 8'(i));
    data_in    = base;
    data_valid = 1'b1;
    while (idx < n && cyc < budget) begin
      @(negedge ifclk);
      take = data_valid && data_ready;
      @(posedge ifclk);
      #1;
      cyc++;
      if (take) begin
        idx++;
        data_in = base + 8'(idx);
      end
      if (idx == n) data_valid = 1'b0;
    end
    data_valid = 1'b0;
    check(name, idx, n);
  endtask

  task automatic wait_cmd_drain(input string name, input int budget);
    int   cyc = 0;
    logic done;
    done = (exp_cmd_q.size() == 0) && !cmd_valid && (dut.state == IDLE);
    while (!done && cyc < budget) begin
      step(1);
      cyc++;
      done = (exp_cmd_q.size() == 0) && !cmd_valid && (dut.state == IDLE);
    end
    check(name, done ? 1 : 0, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int   r0;
    int   p0;
    int   n;
    int   cyc;
    logic take;

    // Reset values
    step(3);
    @(negedge ifclk);
    check("rst_slrd", slrd, 1);
    check("rst_slwr", slwr, 1);
    check("rst_sloe", sloe, 1);
    check("rst_pktend", pktend, 1);
    check("rst_fifoadr", fifoadr, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd_data", cmd_data, 0);
    check("rst_data_ready", data_ready, 0);
    check("rst_fd_oe", dut.fd_oe, 0);
    check("rst_state", int'(dut.state), int'(IDLE));
    check("rst_flush_pending", dut.flush_pending, 0);
    check("rst_beat_cnt", int'(dut.beat_cnt), 0);
    check("rst_rr_write_last", dut.last_wr, 1);
    step(1);
    reset = 1'b0;
    step(2);

    // Three command bytes with the consumer always ready
    cmd_ready = 1'b1;
    r0 = rd_strobes;
    push_cmd(8'hA1);
    push_cmd(8'hA2);
    push_cmd(8'hA3);
    wait_cmd_drain("t1_drain", 40);
    check("t1_slrd_cycles", rd_strobes - r0, 3);
    check("t1_cmd_data_last", cmd_data, 8'hA3);

    // 40 bytes: bursts of 16, 16, 8
    exp_run_q.push_back(16);
    exp_run_q.push_back(16);
    exp_run_q.push_back(8);
    stream("t2_stream_done", 8'h00, 40, 300);
    step(4);
    check("t2_wr_total", total_wr, 40);
    check("t2_state_idle", int'(dut.state), int'(IDLE));

    // 5 bytes then a flush: one packet commit after byte 45 overall
    p0 = pkt_cnt;
    exp_run_q.push_back(5);
    exp_pkt_q.push_back(45);
    stream("t3_stream_done", 8'h80, 5, 50);
    data_flush = 1'b1;
    step(1);
    data_flush = 1'b0;
    step(8);
    check("t3_pktend_cycles", pkt_cnt - p0, 1);
    check("t3_flush_cleared", dut.flush_pending, 0);

    // Both sides busy: grants alternate read, write, read, write
    log_grants = 1'b1;
    exp_grant_q.push_back(1'b0);
    exp_grant_q.push_back(1'b1);
    exp_grant_q.push_back(1'b0);
    exp_grant_q.push_back(1'b1);
    exp_run_q.push_back(16);
    exp_run_q.push_back(4);
    r0 = rd_strobes;
    for (int i = 0; i < 20; i++) push_cmd(8'hB0 + 8'(i));
    stream("t4_stream_done", 8'h40, 20, 400);
    wait_cmd_drain("t4_drain", 100);
    log_grants = 1'b0;
    check("t4_reads", rd_strobes - r0, 20);
    check("t4_grants_left", exp_grant_q.size(), 0);

    // Consumer stalled with two bytes waiting
    cmd_ready = 1'b0;
    r0 = rd_strobes;
    push_cmd(8'hC1);
    push_cmd(8'hC2);
    step(8);
    check("t5_one_read", rd_strobes - r0, 1);
    check("t5_slrd_high", slrd, 1);
    check("t5_cmd_valid", cmd_valid, 1);
    check("t5_cmd_data", cmd_data, 8'hC1);
    cmd_ready = 1'b1;
    wait_cmd_drain("t5_drain", 40);
    check("t5_two_reads", rd_strobes - r0, 2);

    // Reset in the middle of a write burst
    exp_wr_q.push_back(8'hD0);
    exp_wr_q.push_back(8'hD1);
    exp_wr_q.push_back(8'hD2);
    exp_run_q.push_back(3);
    data_in    = 8'hD0;
    data_valid = 1'b1;
    n   = 0;
    cyc = 0;
    while (n < 3 && cyc < 50) begin
      @(negedge ifclk);
      take = data_valid && data_ready;
      @(posedge ifclk);
      #1;
      cyc++;
      if (take) begin
        n++;
        data_in = 8'hD0 + 8'(n);
      end
    end
    check("t6_three_writes", n, 3);
    check("t6_in_write", int'(dut.state), int'(WRITE));
    reset = 1'b1;
    @(negedge ifclk);
    check("t6_slwr_same_cycle", slwr, 1);
    check("t6_fd_oe_same_cycle", dut.fd_oe, 0);
    step(1);
    check("t6_slwr", slwr, 1);
    check("t6_fd_oe", dut.fd_oe, 0);
    check("t6_state", int'(dut.state), int'(IDLE));
    check("t6_data_ready", data_ready, 0);
    data_valid = 1'b0;
    reset = 1'b0;
    step(4);

    // Nothing left outstanding, bus discipline held throughout
    check("end_cmd_q", exp_cmd_q.size(), 0);
    check("end_wr_q", exp_wr_q.size(), 0);
    check("end_run_q", exp_run_q.size(), 0);
    check("end_pkt_q", exp_pkt_q.size(), 0);
    check("end_wr_total", total_wr, 68);
    check("bus_contention", contention, 0);
    check("rd_turnaround", turnaround_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
